// File: rtl/cafe_pkg.sv
// rtl/cafe_pkg.sv - phase codes, default timings and phase ordering for the brew sequencer
package cafe_pkg;

    localparam logic [2:0] FASE_IDLE     = 3'd0;
    localparam logic [2:0] FASE_MOLER    = 3'd1;
    localparam logic [2:0] FASE_CALENTAR = 3'd2;
    localparam logic [2:0] FASE_EXTRAER  = 3'd3;
    localparam logic [2:0] FASE_LECHE    = 3'd4;
    localparam logic [2:0] FASE_ESPUMA   = 3'd5;
    localparam logic [2:0] FASE_AZUCAR   = 3'd6;
    localparam logic [2:0] FASE_ENTREGA  = 3'd7;

    localparam int CW_DEF         = 8;
    localparam int T_MOLER_DEF    = 4;
    localparam int T_CALENTAR_DEF = 6;
    localparam int T_EXTRAER_DEF  = 4;
    localparam int T_CONC_DEF     = 2;
    localparam int T_LECHE_DEF    = 5;
    localparam int T_ESPUMA_DEF   = 3;
    localparam int T_DOSIS_DEF    = 2;
    localparam int T_ENTREGA_DEF  = 2;

    localparam logic [1:0] TAMANO_INVALIDO = 2'd3;

    typedef enum logic [2:0] {
        F_IDLE     = FASE_IDLE,
        F_MOLER    = FASE_MOLER,
        F_CALENTAR = FASE_CALENTAR,
        F_EXTRAER  = FASE_EXTRAER,
        F_LECHE    = FASE_LECHE,
        F_ESPUMA   = FASE_ESPUMA,
        F_AZUCAR   = FASE_AZUCAR,
        F_ENTREGA  = FASE_ENTREGA
    } fase_e;

    // Fixed phase order; optional phases fall straight through to the next needed one.
    function automatic fase_e siguiente_fase(input fase_e f, input logic leche,
                                             input logic espuma, input logic [2:0] azucar);
        fase_e tras_espuma;
        fase_e tras_leche;
        tras_espuma = (azucar != 3'd0) ? F_AZUCAR : F_ENTREGA;
        tras_leche  = espuma ? F_ESPUMA : tras_espuma;
        case (f)
            F_MOLER:    siguiente_fase = F_CALENTAR;
            F_CALENTAR: siguiente_fase = F_EXTRAER;
            F_EXTRAER:  siguiente_fase = leche ? F_LECHE : tras_leche;
            F_LECHE:    siguiente_fase = tras_leche;
            F_ESPUMA:   siguiente_fase = tras_espuma;
            F_AZUCAR:   siguiente_fase = F_ENTREGA;
            default:    siguiente_fase = F_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// rtl/temporizador_fase.sv - loadable down-counter timing the length of each phase
module temporizador_fase #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cargar,
    input  logic [CW-1:0] valor,
    output logic          expirado
);

    logic [CW-1:0] cuenta;

    // Counter parks at zero so expirado stays asserted until the next load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (cargar) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - CW'(1);
        end
    end

    assign expirado = (cuenta == '0);

endmodule

// File: rtl/secuenciador_preparacion.sv
// rtl/secuenciador_preparacion.sv - brew-phase sequencer driving grinder, heater, pump, milk, foam and sugar
module secuenciador_preparacion
    import cafe_pkg::*;
#(
    parameter int CW         = CW_DEF,
    parameter int T_MOLER    = T_MOLER_DEF,
    parameter int T_CALENTAR = T_CALENTAR_DEF,
    parameter int T_EXTRAER  = T_EXTRAER_DEF,
    parameter int T_CONC     = T_CONC_DEF,
    parameter int T_LECHE    = T_LECHE_DEF,
    parameter int T_ESPUMA   = T_ESPUMA_DEF,
    parameter int T_DOSIS    = T_DOSIS_DEF,
    parameter int T_ENTREGA  = T_ENTREGA_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       cancelar,
    input  logic [1:0] tamano,
    input  logic       concentracion,
    input  logic       leche,
    input  logic       espuma,
    input  logic [2:0] azucar,
    output logic       molino_on,
    output logic       calentador_on,
    output logic       bomba_on,
    output logic       valvula_leche_on,
    output logic       espumador_on,
    output logic       dosificador_pulso,
    output logic       ocupado,
    output logic [2:0] fase,
    output logic       listo,
    output logic       abortado,
    output logic       rechazo
);

    fase_e         fase_q;
    fase_e         fase_d;
    logic [1:0]    tamano_q;
    logic          conc_q;
    logic          leche_q;
    logic          espuma_q;
    logic [2:0]    azucar_q;
    logic          capturar;
    logic          cargar;
    logic [CW-1:0] valor;
    logic          expirado;
    logic [CW-1:0] dosis_q;
    logic [CW-1:0] dosis_d;
    logic          listo_d;
    logic          abortado_d;
    logic          rechazo_d;

    // Durations of recipe-dependent phases come from the latched recipe, never the live inputs.
    function automatic logic [CW-1:0] duracion(input fase_e f);
        case (f)
            F_MOLER:    duracion = CW'(T_MOLER);
            F_CALENTAR: duracion = CW'(T_CALENTAR);
            F_EXTRAER:  duracion = CW'(T_EXTRAER) * (CW'(tamano_q) + CW'(1))
                                   + (conc_q ? CW'(T_CONC) : '0);
            F_LECHE:    duracion = CW'(T_LECHE);
            F_ESPUMA:   duracion = CW'(T_ESPUMA);
            F_AZUCAR:   duracion = CW'(azucar_q) * CW'(T_DOSIS);
            F_ENTREGA:  duracion = CW'(T_ENTREGA);
            default:    duracion = '0;
        endcase
    endfunction

    temporizador_fase #(
        .CW(CW)
    ) u_temporizador (
        .clk     (clk),
        .reset   (reset),
        .cargar  (cargar),
        .valor   (valor),
        .expirado(expirado)
    );

    always_comb begin
        fase_d     = fase_q;
        capturar   = 1'b0;
        listo_d    = 1'b0;
        abortado_d = 1'b0;
        rechazo_d  = 1'b0;
        if (fase_q == F_IDLE) begin
            if (inicio) begin
                if (tamano == TAMANO_INVALIDO) begin
                    rechazo_d = 1'b1;
                end else begin
                    fase_d   = F_MOLER;
                    capturar = 1'b1;
                end
            end
        end else if (cancelar) begin
            fase_d     = F_IDLE;
            abortado_d = 1'b1;
        end else if (expirado) begin
            fase_d  = siguiente_fase(fase_q, leche_q, espuma_q, azucar_q);
            listo_d = (fase_d == F_IDLE);
        end

        cargar = (fase_d != fase_q) && (fase_d != F_IDLE);
        valor  = duracion(fase_d) - CW'(1);

        // Position within the current sugar dose; zero marks the dose's first cycle.
        if ((fase_d != F_AZUCAR) || (fase_q != F_AZUCAR) || (dosis_q == CW'(T_DOSIS - 1))) begin
            dosis_d = '0;
        end else begin
            dosis_d = dosis_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fase_q            <= F_IDLE;
            tamano_q          <= '0;
            conc_q            <= 1'b0;
            leche_q           <= 1'b0;
            espuma_q          <= 1'b0;
            azucar_q          <= '0;
            dosis_q           <= '0;
            molino_on         <= 1'b0;
            calentador_on     <= 1'b0;
            bomba_on          <= 1'b0;
            valvula_leche_on  <= 1'b0;
            espumador_on      <= 1'b0;
            dosificador_pulso <= 1'b0;
            ocupado           <= 1'b0;
            listo             <= 1'b0;
            abortado          <= 1'b0;
            rechazo           <= 1'b0;
        end else begin
            fase_q <= fase_d;
            if (capturar) begin
                tamano_q <= tamano;
                conc_q   <= concentracion;
                leche_q  <= leche;
                espuma_q <= espuma;
                azucar_q <= azucar;
            end
            dosis_q           <= dosis_d;
            molino_on         <= (fase_d == F_MOLER);
            calentador_on     <= (fase_d == F_CALENTAR) || (fase_d == F_EXTRAER);
            bomba_on          <= (fase_d == F_EXTRAER);
            valvula_leche_on  <= (fase_d == F_LECHE);
            espumador_on      <= (fase_d == F_ESPUMA);
            dosificador_pulso <= (fase_d == F_AZUCAR) && (dosis_d == '0);
            ocupado           <= (fase_d != F_IDLE);
            listo             <= listo_d;
            abortado          <= abortado_d;
            rechazo           <= rechazo_d;
        end
    end

    assign fase = fase_q;

endmodule

// File: doc/secuenciador_preparacion.md
Name: secuenciador_preparacion

Overview:
Brew-phase sequencer for the coffee machine. Once a selection is valid and paid, `secuenciador_preparacion` takes the recipe flags (`concentracion`, `leche`, `espuma`, `azucar_anadido`, `tamano`) and drives the physical actuators through timed phases. Phases run in a fixed order and phases not needed by the recipe are skipped. It reports busy, done and abort status back to the machine FSM.

Parameters:
CW, 8, width of the phase timer and duration arithmetic
T_MOLER, 4, grind phase length in cycles
T_CALENTAR, 6, heat phase length in cycles
T_EXTRAER, 4, base extraction length; scaled by (tamano+1)
T_CONC, 2, extra extraction cycles when concentracion=1
T_LECHE, 5, milk phase length in cycles
T_ESPUMA, 3, foam phase length in cycles
T_DOSIS, 2, cycles per sugar dose
T_ENTREGA, 2, delivery phase length in cycles

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
inicio  in  1  start request, 1-cycle pulse; sampled only in IDLE
cancelar  in  1  abort request; honoured in any non-IDLE phase
tamano  in  2  cup size 0..2; 3 is invalid
concentracion  in  1  strong brew flag
leche  in  1  milk requested
espuma  in  1  foam requested
azucar  in  3  number of sugar doses, 0..7
molino_on  out  1  grinder enable
calentador_on  out  1  heater enable
bomba_on  out  1  extraction pump enable
valvula_leche_on  out  1  milk valve enable
espumador_on  out  1  frother enable
dosificador_pulso  out  1  sugar dose strobe
ocupado  out  1  high in every non-IDLE phase
fase  out  3  current phase code
listo  out  1  1-cycle completion pulse
abortado  out  1  1-cycle cancel pulse
rechazo  out  1  1-cycle invalid-request pulse

Behaviour:
- Reset (reset=0, asynchronous): fase=IDLE; every output 0; timer 0; latched recipe 0.
- Phase codes: IDLE=0, MOLER=1, CALENTAR=2, EXTRAER=3, LECHE=4, ESPUMA=5, AZUCAR=6, ENTREGA=7.
- Start in IDLE:
  - inicio=1 and tamano!=3: at that edge, latch the recipe inputs and enter MOLER.
  - inicio=1 and tamano=3: stay in IDLE and pulse rechazo for one cycle.
  - Recipe inputs are ignored outside the latching edge.
- Phase duration: every phase lasts exactly its duration D cycles. The timer loads D-1 on entry and moves on at the edge where it reads 0.
- EXTRAER duration = T_EXTRAER*(tamano+1) + (concentracion ? T_CONC : 0), computed in CW bits with no overflow at the default parameters.
- Phase order: MOLER → CALENTAR → EXTRAER → LECHE → ESPUMA → AZUCAR → ENTREGA → IDLE.
  - LECHE is skipped if leche=0.
  - ESPUMA is skipped if espuma=0.
  - AZUCAR is skipped if azucar=0.
  - A skip is a direct transition; skipped phases add no cycles.
- AZUCAR lasts azucar*T_DOSIS cycles. dosificador_pulso is high in the first cycle of each dose, giving exactly `azucar` pulses.
- Actuator mapping (all outputs registered and decoded from the registered phase, so no glitches):
  - molino_on: MOLER
  - calentador_on: CALENTAR and EXTRAER
  - bomba_on: EXTRAER
  - valvula_leche_on: LECHE
  - espumador_on: ESPUMA
- Completion: listo=1 in the first IDLE cycle after ENTREGA completes, for one cycle only.
- Cancel: cancelar=1 in any non-IDLE phase causes the following:
  - At the next edge, go to IDLE and drop all actuators.
  - abortado=1 for one cycle; listo is not asserted.
  - Cancel wins over a simultaneous end of phase, including the last cycle of ENTREGA.
  - cancelar in IDLE is ignored.
- inicio while ocupado=1 is ignored and not queued.
- inicio and cancelar together in IDLE: the start is taken.
- A new inicio is accepted in the same cycle listo is high, since the block is in IDLE then.

Decomposition:
- Package `cafe_pkg`:
  - phase code localparams FASE_IDLE..FASE_ENTREGA
  - default duration constants
  - TAMANO_INVALIDO=2'd3
- Sub-module `temporizador_fase`:
  - CW-bit loadable down-counter
  - inputs: cargar, valor
  - output: expirado (high when count==0)
  - instantiated once inside the sequencer.

Test Plan:
1. Reset mid-EXTRAER: assert reset=0 asynchronously → all outputs 0 and fase=0 immediately, without waiting for a clock; after release the block idles until inicio.
2. Minimal recipe: tamano=0, conc=0, leche=0, espuma=0, azucar=0, inicio pulse.
   - ocupado high for 16 cycles: MOLER 4, CALENTAR 6, EXTRAER 4, ENTREGA 2.
   - fase sequence 1,2,3,7; listo pulses once at cycle 17.
3. Full recipe: tamano=1, conc=1, leche=1, espuma=0, azucar=2.
   - EXTRAER lasts 10 cycles; LECHE 5; ESPUMA skipped; AZUCAR 4.
   - Exactly 2 dosificador_pulso; ocupado for 31 cycles, then listo.
4. Cancel: cancelar=1 on the 3rd cycle of LECHE.
   - Next cycle: fase=0, all actuators 0, abortado=1 for one cycle; no listo.
   - A later start runs normally.
5. Invalid size: inicio with tamano=3 → rechazo for one cycle, fase stays 0, ocupado never asserted.
6. Overlap and priority:
   - inicio pulses during EXTRAER are ignored.
   - cancelar in the final ENTREGA cycle gives abortado=1 and listo=0.
   - inicio in the listo cycle starts a new brew, with fase=1 on the next cycle.
